// File: rtl/boot_loader.sv
// Byte-stream program loader: assembles little-endian words, writes them from
// address 0 upward, and holds the core in reset until the image is in memory.
module boot_loader #(
  parameter int ADDR_W    = 16,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [31:0]       mem_wd,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    CHECK,
    DATA,
    WRITE,
    RUN,
    ERR
  } state_t;

  state_t            state_q;
  logic [15:0]       n_q;
  logic [15:0]       word_idx_q;
  logic [1:0]        byte_cnt_q;
  logic [31:0]       asm_q;
  logic [31:0]       asm_d;
  logic [ADDR_W-1:0] mem_adr_q;
  logic [31:0]       mem_wd_q;
  logic              core_rst_q;
  logic              done_q;
  logic              err_q;

  assign rx_ready = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
  assign mem_we   = (state_q == WRITE);
  assign mem_adr  = mem_adr_q;
  assign mem_wd   = mem_wd_q;
  assign core_rst = core_rst_q;
  assign done     = done_q;
  assign err      = err_q;

  // Word under assembly with the incoming byte dropped into its lane.
  always_comb begin
    asm_d = asm_q;
    case (byte_cnt_q)
      2'd0:    asm_d[7:0]   = rx_data;
      2'd1:    asm_d[15:8]  = rx_data;
      2'd2:    asm_d[23:16] = rx_data;
      default: asm_d[31:24] = rx_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LEN_LO;
      n_q        <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      mem_adr_q  <= '0;
      mem_wd_q   <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        LEN_LO: begin
          if (rx_valid) begin
            n_q[7:0] <= rx_data;
            state_q  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (rx_valid) begin
            n_q[15:8] <= rx_data;
            state_q   <= CHECK;
          end
        end
        CHECK: begin
          if ((n_q == 16'd0) || (32'(n_q) > MAX_WORDS)) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else begin
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (rx_valid) begin
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            // Address/data are latched here so they are stable for the whole WRITE cycle and hold afterwards.
            if (byte_cnt_q == 2'd3) begin
              mem_adr_q <= ADDR_W'({word_idx_q, 2'b00});
              mem_wd_q  <= asm_d;
              state_q   <= WRITE;
            end
          end
        end
        WRITE: begin
          if (word_idx_q == n_q - 16'd1) begin
            state_q    <= RUN;
            core_rst_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            word_idx_q <= word_idx_q + 16'd1;
            byte_cnt_q <= '0;
            state_q    <= DATA;
          end
        end
        RUN, ERR: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= LEN_LO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: table of complete loads plus hand-written
// sequences for the maximum-size image and a reset in the middle of a load.
module tb_boot_loader;

  localparam int ADDR_W    = 16;
  localparam int MAX_WORDS = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_adr;
  logic [31:0]       mem_wd;
  logic              core_rst;
  logic              done;
  logic              err;

  int errors = 0;
  int checks = 0;

  logic [31:0] wadr[$];
  logic [31:0] wdat[$];

  typedef struct {
    logic [15:0]      n;
    int               nw;
    logic [3:0][31:0] w;
    int               gap;
    bit               exp_err;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .mem_we   (mem_we),
    .mem_adr  (mem_adr),
    .mem_wd   (mem_wd),
    .core_rst (core_rst),
    .done     (done),
    .err      (err)
  );

  // Every cycle with mem_we high is logged as one write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wadr.push_back(32'(mem_adr));
      wdat.push_back(mem_wd);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must react at once.
  task automatic apply_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_core_rst", {31'b0, core_rst}, 32'd1);
    check("rst_mem_we",   {31'b0, mem_we},   32'd0);
    check("rst_done",     {31'b0, done},     32'd0);
    check("rst_err",      {31'b0, err},      32'd0);
    check("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
    @(negedge clk);
    rst      = 1'b0;
    rx_valid = 1'b0;
    wadr.delete();
    wdat.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g;
    int t;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (g) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (rx_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      check("rx_ready_timeout", {31'b0, rx_ready}, 32'd1);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], maxgap);
    end
  endtask

  // Called right after the edge that took the final byte: one WRITE cycle, then RUN.
  task automatic finish_ok(input string tag);
    @(negedge clk);
    check({tag, "_last_we"},       {31'b0, mem_we},   32'd1);
    check({tag, "_wr_core_rst"},   {31'b0, core_rst}, 32'd1);
    check({tag, "_wr_done"},       {31'b0, done},     32'd0);
    check({tag, "_wr_rx_ready"},   {31'b0, rx_ready}, 32'd0);
    @(negedge clk);
    check({tag, "_run_core_rst"},  {31'b0, core_rst}, 32'd0);
    check({tag, "_run_done"},      {31'b0, done},     32'd1);
    check({tag, "_run_err"},       {31'b0, err},      32'd0);
    check({tag, "_run_we"},        {31'b0, mem_we},   32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_run_rx_ready"},  {31'b0, rx_ready}, 32'd0);
    rx_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'd2,    2, {32'h0, 32'h0, 32'h00100113, 32'h00500093}, 0, 1'b0};
    vecs[1] = '{16'd2,    2, {32'h0, 32'h0, 32'h00100113, 32'h00500093}, 5, 1'b0};
    vecs[2] = '{16'd0,    0, {32'h0, 32'h0, 32'h0, 32'h0},               0, 1'b1};
    vecs[3] = '{16'd1025, 0, {32'h0, 32'h0, 32'h0, 32'h0},               2, 1'b1};
    vecs[4] = '{16'd1,    1, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},        1, 1'b0};
    vecs[5] = '{16'd3,    3, {32'h0, 32'hFFFFFFFF, 32'hA0B0C0D0, 32'h01020304}, 3, 1'b0};
    vecs[6] = '{16'hFFFF, 0, {32'h0, 32'h0, 32'h0, 32'h0},               0, 1'b1};

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      apply_reset();
      send_byte(vecs[v].n[7:0],  vecs[v].gap);
      send_byte(vecs[v].n[15:8], vecs[v].gap);
      if (vecs[v].exp_err) begin
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        @(negedge clk);
        check($sformatf("v%0d_check_err", v),   {31'b0, err},      32'd0);
        check($sformatf("v%0d_check_ready", v), {31'b0, rx_ready}, 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_err", v),         {31'b0, err},      32'd1);
        check($sformatf("v%0d_err_core", v),    {31'b0, core_rst}, 32'd1);
        repeat (4) @(negedge clk);
        check($sformatf("v%0d_err_refuse", v),  {31'b0, rx_ready}, 32'd0);
        check($sformatf("v%0d_err_done", v),    {31'b0, done},     32'd0);
        check($sformatf("v%0d_err_hold", v),    {31'b0, err},      32'd1);
        check($sformatf("v%0d_err_writes", v),  32'(wadr.size()),  32'd0);
        rx_valid = 1'b0;
      end else begin
        for (int i = 0; i < vecs[v].nw; i++) begin
          send_word(vecs[v].w[i], vecs[v].gap);
        end
        finish_ok($sformatf("v%0d", v));
        check($sformatf("v%0d_nwrites", v), 32'(wadr.size()), 32'(vecs[v].nw));
        for (int i = 0; i < vecs[v].nw && i < wadr.size(); i++) begin
          check($sformatf("v%0d_adr%0d", v, i), wadr[i], 32'(i * 4));
          check($sformatf("v%0d_wd%0d", v, i),  wdat[i], vecs[v].w[i]);
        end
      end
    end

    // Largest legal image: every word is distinct so a dropped or repeated byte shows up.
    begin
      int bad;
      logic [31:0] w;
      apply_reset();
      send_byte(8'h00, 0);
      send_byte(8'h04, 0);
      for (int i = 0; i < MAX_WORDS; i++) begin
        w = {16'(i) ^ 16'hA5C3, 16'(i)};
        send_word(w, 0);
      end
      finish_ok("max");
      check("max_nwrites", 32'(wadr.size()), 32'(MAX_WORDS));
      bad = 0;
      for (int i = 0; i < wadr.size(); i++) begin
        w = {16'(i) ^ 16'hA5C3, 16'(i)};
        if (wadr[i] !== 32'(i * 4) || wdat[i] !== w) bad++;
      end
      check("max_bad_words", 32'(bad), 32'd0);
      if (wadr.size() > 0) begin
        check("max_last_adr", wadr[wadr.size() - 1], 32'h0000_0FFC);
        check("max_last_wd",  wdat[wdat.size() - 1], {16'(MAX_WORDS - 1) ^ 16'hA5C3, 16'(MAX_WORDS - 1)});
      end
    end

    // Reset after five bytes of a two-word load, then a fresh single-word load.
    apply_reset();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_core_rst", {31'b0, core_rst}, 32'd1);
    check("mid_rx_ready", {31'b0, rx_ready}, 32'd1);
    check("mid_mem_we",   {31'b0, mem_we},   32'd0);
    check("mid_done",     {31'b0, done},     32'd0);
    check("mid_err",      {31'b0, err},      32'd0);
    check("mid_writes",   32'(wadr.size()),  32'd0);
    @(negedge clk);
    rst      = 1'b0;
    rx_valid = 1'b0;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'h12345678, 0);
    finish_ok("mid");
    check("mid_nwrites", 32'(wadr.size()), 32'd1);
    if (wadr.size() > 0) begin
      check("mid_adr", wadr[0], 32'h0);
      check("mid_wd",  wdat[0], 32'h12345678);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
